// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM encoding, default bus widths and response codes.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 8;

    localparam logic APB_RESP_OKAY = 1'b0;
    localparam logic APB_RESP_ERR  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_READY = 2'b11
    } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x DATA_W register storage: one synchronous write port, one combinational read port.
module apb_regfile #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_in_range_c;
    logic              rd_in_range_c;

    // Guards keep non-power-of-two depths from touching absent entries.
    assign wr_in_range_c = {1'b0, waddr} < (IDX_W + 1)'(DEPTH);
    assign rd_in_range_c = {1'b0, raddr} < (IDX_W + 1)'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we && wr_in_range_c) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = rd_in_range_c ? mem_q[raddr] : '0;

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer with a byte register file, programmable wait states and PSLVERR on
// out-of-range addresses. Address, direction and write data are captured in setup.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int unsigned       ADDR_W      = APB_ADDR_W,
    parameter int unsigned       DATA_W      = APB_DATA_W,
    parameter int unsigned       DEPTH       = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       WAIT_CYCLES = 1
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = 4;

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic [ADDR_W-1:0] paddr_off_c;
    logic              paddr_err_c;
    logic              we_c;
    logic [IDX_W-1:0]  widx_c;
    logic [IDX_W-1:0]  ridx_c;
    logic [DATA_W-1:0] rdata_c;

    // Offset is only meaningful when PADDR >= BASE_ADDR; the extra bit lets DEPTH = 2^ADDR_W.
    assign paddr_off_c = PADDR - BASE_ADDR;
    assign paddr_err_c = (PADDR < BASE_ADDR) ||
                         ({1'b0, paddr_off_c} >= (ADDR_W + 1)'(DEPTH));

    assign widx_c = IDX_W'(addr_q - BASE_ADDR);
    assign ridx_c = IDX_W'(addr_d - BASE_ADDR);

    apb_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk   (PCLK),
        .rst   (PRESET),
        .we    (we_c),
        .waddr (widx_c),
        .wdata (wdata_q),
        .raddr (ridx_c),
        .rdata (rdata_c)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            err_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= APB_RESP_OKAY;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            write_q   <= write_d;
            err_q     <= err_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        err_d   = err_q;
        we_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    write_d = PWRITE;
                    err_d   = paddr_err_c;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_READY;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (!PSEL) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_READY;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READY: begin
                state_d = ST_IDLE;
                we_c    = PSEL && PENABLE && write_q && !err_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Response is registered on entry to READY so it holds for the whole completion cycle.
        pready_d  = (state_d == ST_READY);
        pslverr_d = (pready_d && err_d) ? APB_RESP_ERR : APB_RESP_OKAY;
        prdata_d  = (pready_d && !write_d && !err_d) ? rdata_c : '0;
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: three instances with 1, 0 and 3 wait states.
module tb_apb_slave_regfile;
    import apb_pkg::*;

    localparam int D_W1 = 0;
    localparam int D_W0 = 1;
    localparam int D_W3 = 2;

    logic       clk;
    logic       rst     [3];
    logic       psel    [3];
    logic       penable [3];
    logic       pwrite  [3];
    logic [7:0] paddr   [3];
    logic [7:0] pwdata  [3];
    logic [7:0] prdata  [3];
    logic       pready  [3];
    logic       pslverr [3];

    int n_cmp;
    int n_err;

    apb_slave_regfile #(.WAIT_CYCLES(1)) u_w1 (
        .PCLK(clk), .PRESET(rst[D_W1]), .PSEL(psel[D_W1]), .PENABLE(penable[D_W1]),
        .PWRITE(pwrite[D_W1]), .PADDR(paddr[D_W1]), .PWDATA(pwdata[D_W1]),
        .PRDATA(prdata[D_W1]), .PREADY(pready[D_W1]), .PSLVERR(pslverr[D_W1])
    );

    apb_slave_regfile #(.WAIT_CYCLES(0)) u_w0 (
        .PCLK(clk), .PRESET(rst[D_W0]), .PSEL(psel[D_W0]), .PENABLE(penable[D_W0]),
        .PWRITE(pwrite[D_W0]), .PADDR(paddr[D_W0]), .PWDATA(pwdata[D_W0]),
        .PRDATA(prdata[D_W0]), .PREADY(pready[D_W0]), .PSLVERR(pslverr[D_W0])
    );

    apb_slave_regfile #(.WAIT_CYCLES(3)) u_w3 (
        .PCLK(clk), .PRESET(rst[D_W3]), .PSEL(psel[D_W3]), .PENABLE(penable[D_W3]),
        .PWRITE(pwrite[D_W3]), .PADDR(paddr[D_W3]), .PWDATA(pwdata[D_W3]),
        .PRDATA(prdata[D_W3]), .PREADY(pready[D_W3]), .PSLVERR(pslverr[D_W3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Setup phase, then access until PREADY; bus is left in access state for a back-to-back follow-on.
    task automatic apb_xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] wd,
                            output logic [7:0] rd, output logic err, output int cycles);
        @(posedge clk); #1;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
        @(posedge clk); #1;
        penable[d] = 1'b1;
        cycles = 0;
        rd = 8'h00;
        err = 1'b0;
        forever begin
            @(negedge clk);
            cycles++;
            if (pready[d] === 1'b1) begin
                rd = prdata[d];
                err = pslverr[d];
                break;
            end
            if (cycles > 40) begin
                n_cmp++; n_err++;
                $display("FAIL timeout dut=%0d addr=%h: PREADY never rose within 40 cycles", d, a);
                break;
            end
        end
    endtask

    task automatic bus_idle(input int d);
        @(posedge clk); #1;
        psel[d] = 1'b0; penable[d] = 1'b0;
    endtask

    task automatic test_reset;
        for (int d = 0; d < 3; d++) rst[d] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                n_cmp++;
                if ({pready[d], pslverr[d], prdata[d]} !== 10'h000) begin
                    n_err++;
                    $display("FAIL reset_idle dut=%0d cyc=%0d: got rdy=%b err=%b data=%h, want 0/0/00",
                             d, c, pready[d], pslverr[d], prdata[d]);
                end
            end
        end
    endtask

    task automatic test_write_read_w1;
        logic [7:0] rd; logic err; int cyc;
        apb_xfer(D_W1, 1'b1, 8'h03, 8'hA5, rd, err, cyc);
        n_cmp++;
        if (cyc !== 2 || err !== 1'b0) begin
            n_err++;
            $display("FAIL w1_write_lat: got cycles=%0d err=%b, want 2/0", cyc, err);
        end
        bus_idle(D_W1);
        apb_xfer(D_W1, 1'b0, 8'h03, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'hA5 || err !== 1'b0 || cyc !== 2) begin
            n_err++;
            $display("FAIL w1_read: got data=%h err=%b cycles=%0d, want A5/0/2", rd, err, cyc);
        end
        bus_idle(D_W1);
    endtask

    task automatic test_zero_wait;
        logic [7:0] rd; logic err; int cyc;
        apb_xfer(D_W0, 1'b1, 8'h0F, 8'h3C, rd, err, cyc);
        n_cmp++;
        if (cyc !== 1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL w0_write_lat: got cycles=%0d err=%b, want 1/0", cyc, err);
        end
        bus_idle(D_W0);
        apb_xfer(D_W0, 1'b0, 8'h0F, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'h3C || err !== 1'b0 || cyc !== 1) begin
            n_err++;
            $display("FAIL w0_read: got data=%h err=%b cycles=%0d, want 3C/0/1", rd, err, cyc);
        end
        bus_idle(D_W0);
    endtask

    task automatic test_out_of_range;
        logic [7:0] rd; logic err; int cyc;
        apb_xfer(D_W1, 1'b1, 8'h00, 8'h5A, rd, err, cyc);
        bus_idle(D_W1);
        apb_xfer(D_W1, 1'b1, 8'h10, 8'hFF, rd, err, cyc);
        n_cmp++;
        if (err !== APB_RESP_ERR || cyc !== 2) begin
            n_err++;
            $display("FAIL oor_write: got err=%b cycles=%0d, want 1/2", err, cyc);
        end
        bus_idle(D_W1);
        apb_xfer(D_W1, 1'b0, 8'h00, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'h5A || err !== 1'b0) begin
            n_err++;
            $display("FAIL oor_prior: got data=%h err=%b, want 5A/0", rd, err);
        end
        bus_idle(D_W1);
        apb_xfer(D_W1, 1'b0, 8'h10, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'h00 || err !== APB_RESP_ERR) begin
            n_err++;
            $display("FAIL oor_read10: got data=%h err=%b, want 00/1", rd, err);
        end
        bus_idle(D_W1);
        apb_xfer(D_W1, 1'b0, 8'hFF, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'h00 || err !== APB_RESP_ERR) begin
            n_err++;
            $display("FAIL oor_readFF: got data=%h err=%b, want 00/1", rd, err);
        end
        bus_idle(D_W1);
    endtask

    task automatic test_stray_enable;
        @(posedge clk); #1;
        psel[D_W1] = 1'b1; penable[D_W1] = 1'b1; pwrite[D_W1] = 1'b1;
        paddr[D_W1] = 8'h03; pwdata[D_W1] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pready[D_W1] !== 1'b0) begin
                n_err++;
                $display("FAIL stray_enable cyc=%0d: got PREADY=%b, want 0", c, pready[D_W1]);
            end
        end
        bus_idle(D_W1);
    endtask

    task automatic test_abort;
        logic [7:0] rd; logic err; int cyc;
        @(posedge clk); #1;
        psel[D_W3] = 1'b1; penable[D_W3] = 1'b0; pwrite[D_W3] = 1'b1;
        paddr[D_W3] = 8'h05; pwdata[D_W3] = 8'hA0;
        @(posedge clk); #1;
        penable[D_W3] = 1'b1;
        @(posedge clk); #1;
        psel[D_W3] = 1'b0; penable[D_W3] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (pready[D_W3] !== 1'b0) begin
                n_err++;
                $display("FAIL abort_idle cyc=%0d: got PREADY=%b, want 0", c, pready[D_W3]);
            end
        end
        apb_xfer(D_W3, 1'b0, 8'h05, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'h00 || err !== 1'b0 || cyc !== 4) begin
            n_err++;
            $display("FAIL abort_nowrite: got data=%h err=%b cycles=%0d, want 00/0/4", rd, err, cyc);
        end
        bus_idle(D_W3);
    endtask

    task automatic test_reset_mid;
        logic [7:0] rd; logic err; int cyc;
        apb_xfer(D_W3, 1'b1, 8'h06, 8'h77, rd, err, cyc);
        bus_idle(D_W3);
        apb_xfer(D_W3, 1'b0, 8'h06, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'h77 || err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_pre_read: got data=%h err=%b, want 77/0", rd, err);
        end
        bus_idle(D_W3);
        @(posedge clk); #1;
        psel[D_W3] = 1'b1; penable[D_W3] = 1'b0; pwrite[D_W3] = 1'b1;
        paddr[D_W3] = 8'h06; pwdata[D_W3] = 8'h99;
        @(posedge clk); #1;
        penable[D_W3] = 1'b1;
        @(negedge clk);
        rst[D_W3] = 1'b1;
        #1;
        n_cmp++;
        if ({pready[D_W3], pslverr[D_W3], prdata[D_W3]} !== 10'h000) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got rdy=%b err=%b data=%h, want 0/0/00",
                     pready[D_W3], pslverr[D_W3], prdata[D_W3]);
        end
        @(posedge clk); #1;
        psel[D_W3] = 1'b0; penable[D_W3] = 1'b0;
        @(posedge clk); #1;
        rst[D_W3] = 1'b0;
        apb_xfer(D_W3, 1'b0, 8'h06, 8'h00, rd, err, cyc);
        n_cmp++;
        if (rd !== 8'h00 || err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_cleared: got data=%h err=%b, want 00/0", rd, err);
        end
        bus_idle(D_W3);
    endtask

    task automatic test_back_to_back;
        logic [7:0] rd1, rd2; logic e1, e2, e3, e4; int c1, c2, c3, c4;
        logic [7:0] dummy;
        apb_xfer(D_W1, 1'b1, 8'h01, 8'h11, dummy, e1, c1);
        apb_xfer(D_W1, 1'b1, 8'h02, 8'h22, dummy, e2, c2);
        apb_xfer(D_W1, 1'b0, 8'h01, 8'h00, rd1, e3, c3);
        apb_xfer(D_W1, 1'b0, 8'h02, 8'h00, rd2, e4, c4);
        bus_idle(D_W1);
        n_cmp++;
        if ({e1, e2, e3, e4} !== 4'b0000 || c1 !== 2 || c2 !== 2 || c3 !== 2 || c4 !== 2) begin
            n_err++;
            $display("FAIL b2b_timing: got err=%b%b%b%b cycles=%0d/%0d/%0d/%0d, want 0000 2/2/2/2",
                     e1, e2, e3, e4, c1, c2, c3, c4);
        end
        n_cmp++;
        if (rd1 !== 8'h11) begin
            n_err++;
            $display("FAIL b2b_read01: got %h, want 11", rd1);
        end
        n_cmp++;
        if (rd2 !== 8'h22) begin
            n_err++;
            $display("FAIL b2b_read02: got %h, want 22", rd2);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 8'h00; pwdata[d] = 8'h00;
        end
        test_reset();
        test_write_read_w1();
        test_zero_wait();
        test_out_of_range();
        test_stray_enable();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
